// File: rtl/shift_seq_pkg.sv
// Shared state encoding and parity-width constant for the serializer controller.
// Optional parity slot is enabled by SHIFT_SEQ_CTRL_PARITY_EN.
package shift_seq_pkg;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
  localparam int PAR_W = 1;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;
`else
  localparam int PAR_W = 0;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd3
  } state_e;
`endif
endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out register; MSB_FIRST selects which end is presented
// on sout and the shift direction.
module piso_shift_reg #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);
  logic [WIDTH-1:0] sr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= din;
    end else if (shift_en) begin
      if (MSB_FIRST != 0) sr_q <= {sr_q[WIDTH-2:0], 1'b0};
      else                sr_q <= {1'b0, sr_q[WIDTH-1:1]};
    end
  end

  assign sout = (MSB_FIRST != 0) ? sr_q[WIDTH-1] : sr_q[0];
endmodule

// File: rtl/shift_seq_ctrl.sv
// Frame serializer: accepts a parallel word, shifts it out holding each bit
// CLK_DIV cycles, then pulses done. SHIFT_SEQ_CTRL_PARITY_EN adds an even-parity bit.
//
// state    | meaning
// ST_IDLE  | waiting for a word, in_ready high once out of reset
// ST_SHIFT | data bits on sout, sout_en high
// ST_PAR   | even-parity bit on sout (parity build only)
// ST_DONE  | one-cycle done pulse, then back to idle
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int CLK_DIV   = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_en,
  output logic             busy,
  output logic             done
);
  // Bit counter also walks the parity slot, so it is sized for the whole frame.
  localparam int FRAME_BITS = WIDTH + PAR_W;
  localparam int BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_e           state_q, state_d;
  logic [BIT_W-1:0] bit_q;
  logic [DIV_W-1:0] div_q;
  logic             armed_q;
  logic             load, shift_en, sr_out;
  logic             div_last, bit_data_last, bit_term;

  assign div_last      = (div_q == DIV_W'(CLK_DIV - 1));
  assign bit_data_last = (bit_q == BIT_W'(WIDTH - 1));
  assign bit_term      = (bit_q == BIT_W'(FRAME_BITS - 1));

  piso_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_sr (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift_en (shift_en),
    .din      (in_data),
    .sout     (sr_out)
  );

`ifdef SHIFT_SEQ_CTRL_PARITY_EN
  logic par_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      par_q <= 1'b0;
    else if (load) par_q <= ^in_data;
  end
`endif

  // Keeps in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) armed_q <= 1'b0;
    else      armed_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
      bit_q <= '0;
    end else if (load) begin
      div_q <= '0;
      bit_q <= '0;
    end else if (busy) begin
      if (div_last) begin
        div_q <= '0;
        if (!bit_term) bit_q <= bit_q + 1'b1;
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    shift_en = 1'b0;
    in_ready = 1'b0;
    sout     = 1'b0;
    sout_en  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = armed_q;
        if (in_valid && armed_q) begin
          load    = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sout    = sr_out;
        sout_en = 1'b1;
        busy    = 1'b1;
        if (div_last) begin
          shift_en = 1'b1;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
          if (bit_data_last) state_d = ST_PAR;
`else
          if (bit_data_last) state_d = ST_DONE;
`endif
        end
      end
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
      ST_PAR: begin
        sout    = par_q;
        sout_en = 1'b1;
        busy    = 1'b1;
        if (div_last) state_d = ST_DONE;
      end
`endif
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench: three serializer instances (default, LSB-first, CLK_DIV=3)
// with directed frames, back-to-back, in_valid abuse and mid-frame reset.
module tb_shift_seq_ctrl;
  localparam int N = 3;
  localparam int DIVS [N] = '{1, 1, 3};
  localparam int MSBS [N] = '{1, 0, 1};
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0] in_valid, in_ready, sout, sout_en, busy, done;
  logic [3:0]   in_data [N];

  int total = 0;
  int bad   = 0;
  bit exp_q   [N][$];
  int exp_len [N][$];
  int en_cnt  [N];
  bit last_en [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    shift_seq_ctrl #(.WIDTH(4), .CLK_DIV(DIVS[g]), .MSB_FIRST(MSBS[g])) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid[g]),
      .in_data  (in_data[g]),
      .in_ready (in_ready[g]),
      .sout     (sout[g]),
      .sout_en  (sout_en[g]),
      .busy     (busy[g]),
      .done     (done[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected serial bits and frame lengths as the DUTs present them.
  always @(negedge clk) begin
    for (int g = 0; g < N; g++) begin
      if (!rst) begin
        en_cnt[g]  = 0;
        last_en[g] = 1'b0;
      end else begin
        if (sout_en[g]) begin
          check($sformatf("busy_with_bit[%0d]", g), 32'(busy[g]), 32'd1);
          check($sformatf("ready_low_in_frame[%0d]", g), 32'(in_ready[g]), 32'd0);
          total++;
          if (exp_q[g].size() == 0) begin
            bad++;
            $display("FAIL extra_bit[%0d]: got sout_en=1 expected no bit", g);
          end else begin
            bit e;
            total--;
            e = exp_q[g].pop_front();
            check($sformatf("sout[%0d]", g), 32'(sout[g]), 32'(e));
          end
          en_cnt[g]++;
        end
        if (done[g]) begin
          check($sformatf("done_after_bits[%0d]", g), 32'(last_en[g]), 32'd1);
          check($sformatf("done_idle_outs[%0d]", g), {29'd0, sout_en[g], busy[g], in_ready[g]}, 32'd0);
          total++;
          if (exp_len[g].size() == 0) begin
            bad++;
            $display("FAIL spurious_done[%0d]: got done=1 expected 0", g);
          end else begin
            int l;
            total--;
            l = exp_len[g].pop_front();
            check($sformatf("frame_len[%0d]", g), 32'(en_cnt[g]), 32'(l));
          end
          en_cnt[g] = 0;
        end
        last_en[g] = sout_en[g];
      end
    end
  end

  // Called at a negedge; order holds the expected bits, first-out at index 3.
  task automatic send(input int g, input logic [3:0] word, input logic [3:0] order,
                      input bit par, input bit hold);
    int n = 0;
    while (!in_ready[g] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("ready_wait[%0d]", g), 32'(in_ready[g]), 32'd1);
    for (int i = 3; i >= 0; i--)
      repeat (DIVS[g]) exp_q[g].push_back(order[i]);
    if (PB != 0) repeat (DIVS[g]) exp_q[g].push_back(par);
    exp_len[g].push_back((4 + PB) * DIVS[g]);
    in_valid[g] = 1'b1;
    in_data[g]  = word;
    @(posedge clk);
    #1;
    if (!hold) in_valid[g] = 1'b0;
  endtask

  // Counts cycles after acceptance to done, then checks in_ready the cycle after.
  task automatic wait_done(input int g);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
      if (in_valid[g] && !done[g]) begin
        check($sformatf("ready_ignored_valid[%0d]", g), 32'(in_ready[g]), 32'd0);
        in_data[g] = ~in_data[g];
      end
    end while (!done[g] && c < 200);
    in_valid[g] = 1'b0;
    check($sformatf("done_latency[%0d]", g), 32'(c), 32'((4 + PB) * DIVS[g] + 1));
    @(negedge clk);
    check($sformatf("ready_after_done[%0d]", g), 32'(in_ready[g]), 32'd1);
  endtask

  initial begin
    in_valid = '0;
    for (int g = 0; g < N; g++) in_data[g] = 4'h0;
    rst = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_sout", 32'(sout), 32'd0);
    check("rst_sout_en", 32'(sout_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("ready_first_edge", 32'(in_ready), 32'b111);
    @(negedge clk);

    send(0, 4'b1011, 4'b1011, 1'b1, 1'b0);
    wait_done(0);
    send(0, 4'b0110, 4'b0110, 1'b0, 1'b0);   // earliest back-to-back acceptance
    wait_done(0);
    send(1, 4'b1011, 4'b1101, 1'b1, 1'b0);
    wait_done(1);
    send(2, 4'b0110, 4'b0110, 1'b0, 1'b0);
    wait_done(2);
    send(0, 4'b1100, 4'b1100, 1'b0, 1'b1);   // in_valid held, in_data toggled mid-frame
    wait_done(0);

    send(0, 4'b1011, 4'b1011, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_sout", 32'(sout), 32'd0);
    check("midrst_sout_en", 32'(sout_en), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd0);
    for (int g = 0; g < N; g++) begin
      exp_q[g].delete();
      exp_len[g].delete();
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_midrst", 32'(in_ready[0]), 32'd1);
    @(negedge clk);
    send(0, 4'b0110, 4'b0110, 1'b0, 1'b0);
    wait_done(0);
    send(2, 4'b1011, 4'b1011, 1'b1, 1'b0);
    wait_done(2);

    repeat (3) @(negedge clk);
    for (int g = 0; g < N; g++)
      check($sformatf("drained[%0d]", g), 32'(exp_q[g].size() + exp_len[g].size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
